store_narrower: RTL
===================

Name: store_narrower

Overview:
- Store-side counterpart to the immediate/load extender: takes a 32-bit register value and narrows it to byte, halfword or word width.
- Places the narrowed value on the correct little-endian byte lanes with byte enables.
- Buffers stores in a small FIFO and issues them to data memory over a valid/ready handshake.
- Sits between the EX/MEM stage (sw/sh/sb) and the data-memory port.

Parameters:
- DEPTH, 2, number of buffered store entries (power of two, ≥2)
- AW, 32, address width

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  synchronous, active-high reset
- In_Valid  in  1  store request valid
- In_Ready  out  1  store request can be accepted
- In_Data  in  32  register value to store
- In_Addr  in  AW  byte address
- In_Size  in  2  00 byte, 01 half, 10 word, 11 reserved
- Mem_Valid  out  1  memory write request valid
- Mem_Ready  in  1  memory accepts request
- Mem_Addr  out  AW  word-aligned address {In_Addr[AW-1:2],2'b00}
- Mem_Data  out  32  lane-positioned data
- Mem_Be  out  4  byte enables, bit i = byte lane i (bits 8i+7:8i)
- Misalign  out  1  one-cycle pulse: request rejected
- Count  out  log2(DEPTH)+1  entries held

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high (reset).
- Reset values:
  - Count=0, Mem_Valid=0, Misalign=0, Mem_Addr=0, Mem_Data=0, Mem_Be=0.
  - Reset mid-operation discards all buffered entries; nothing is issued after it.
- Handshake:
  - In_Ready = (Count < DEPTH), registered-state-derived only; no combinational path from Mem_Ready.
  - Accept when In_Valid & In_Ready at a rising edge.
- Legality check at accept:
  - Reject when In_Size=11, or half with In_Addr[0]=1, or word with In_Addr[1:0]≠00.
  - A rejected request is consumed (handshake completes) but not enqueued.
  - Misalign=1 for exactly the cycle after the accept edge.
- Entry formation (combinational before enqueue), lane L=In_Addr[1:0]:
  - byte: Data={4{In_Data[7:0]}}, Be=4'b0001<<L
  - half: Data={2{In_Data[15:0]}}, Be=4'b0011<<L
  - word: Data=In_Data, Be=4'b1111
  - Upper bits of In_Data beyond the size are discarded (truncation).
- FIFO:
  - Circular buffer with wr/rd pointers wrapping modulo DEPTH; Count tracks occupancy.
  - Head entry drives Mem_Addr/Mem_Data/Mem_Be; Mem_Valid = (Count≠0).
  - Pop on Mem_Valid & Mem_Ready.
  - Head outputs are stable while Mem_Valid=1 and Mem_Ready=0.
- Simultaneous push and pop: Count unchanged, both pointers advance. Allowed at any Count where In_Ready=1.
- Full: In_Ready=0; In_Valid held by the upstream stage. A pop at full raises In_Ready the next cycle (no same-cycle bypass).
- Empty: Mem_Valid=0 and Mem_* hold their last values. No data bypass: an accepted entry appears on Mem_* one cycle after the accept edge, earliest Mem_Valid.
- Ordering: strict in-order issue.

Optional Feature:
- Macro: STORE_NARROWER_TRUNC_CHECK_EN.
- With the macro: adds output Trunc_Loss (1 bit, reset 0).
  - Pulses for one cycle after accepting a legal byte or half store whose discarded upper bits are neither all-zero nor the sign-extension of the stored top bit.
  - Equivalent condition: the stored field, when read back through the sign or zero extender, would not reproduce In_Data.
  - The store is still enqueued normally.
- Without the macro: port absent, no check logic.

Test Plan:
- Reset, then In_Valid=1, Size=10, Addr=0x100, Data=0xDEADBEEF, Mem_Ready=1 -> next cycle Mem_Valid=1, Mem_Addr=0x100, Mem_Be=1111, Mem_Data=0xDEADBEEF; Count returns 0 after the pop.
- Byte stores of Data=0x123456AB to Addr 0x200..0x203 -> Mem_Data=0xABABABAB each; Mem_Be=0001,0010,0100,1000; Mem_Addr=0x200.
- Half store Data=0xFFFF8001 to Addr 0x302 -> Mem_Be=1100, Mem_Data=0x80018001. Half to 0x301 -> Misalign pulse, Count unchanged, no Mem_Valid.
- Mem_Ready=0, push three words -> Count=2, In_Ready=0 after the second accept, third held. Raise Mem_Ready -> issued in order with Mem_* stable while stalled; third accepted the cycle after the first pop.
- Count=1 with simultaneous push and pop -> Count stays 1. Assert reset with Count=2 -> next cycle Count=0, Mem_Valid=0, no further issue.
- Macro on: byte store Data=0x00000180 -> Trunc_Loss=1. Data=0xFFFFFF80 -> 0. Data=0x0000007F -> 0.

Source files
------------

// File: rtl/store_narrower.sv
// store_narrower: narrows a 32-bit store to byte, halfword or word width,
// places it on the little-endian byte lanes with byte enables, and buffers
// it in a DEPTH-entry FIFO that issues to data memory over valid/ready.
//
// Optional build macro: STORE_NARROWER_TRUNC_CHECK_EN
//   When defined, adds output Trunc_Loss, a one-cycle pulse after accepting
//   a legal byte/half store whose discarded upper bits are neither zero nor
//   the sign extension of the stored field.
//
// Timing notes:
//   - In_Ready depends only on the registered occupancy, so there is no
//     combinational path from Mem_Ready to In_Ready.
//   - The Mem_* head outputs are registered. They are reloaded every cycle
//     with whatever the head will be after this edge. When the buffer goes
//     empty they keep their last values.
//   - There is no bypass. An accepted store shows up on Mem_* one cycle
//     after its accept edge at the earliest.

module store_narrower #(
   parameter int DEPTH = 2,
   parameter int AW    = 32
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     In_Valid,
   output logic                     In_Ready,
   input  logic [31:0]              In_Data,
   input  logic [AW-1:0]            In_Addr,
   input  logic [1:0]               In_Size,
   output logic                     Mem_Valid,
   input  logic                     Mem_Ready,
   output logic [AW-1:0]            Mem_Addr,
   output logic [31:0]              Mem_Data,
   output logic [3:0]               Mem_Be,
   output logic                     Misalign,
`ifdef STORE_NARROWER_TRUNC_CHECK_EN
   output logic                     Trunc_Loss,
`endif
   output logic [$clog2(DEPTH):0]   Count
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b10;

   // Buffer storage (no reset needed; occupancy qualifies every entry).
   logic [AW-1:0]   r_ent_addr [DEPTH];
   logic [31:0]     r_ent_data [DEPTH];
   logic [3:0]      r_ent_be   [DEPTH];

   logic [PW-1:0]   r_wr_ptr;
   logic [PW-1:0]   r_rd_ptr;
   logic [CW-1:0]   r_count;

   logic [AW-1:0]   r_mem_addr;
   logic [31:0]     r_mem_data;
   logic [3:0]      r_mem_be;
   logic            r_misalign;

   logic [1:0]      w_lane;
   logic [AW-1:0]   w_addr;
   logic [31:0]     w_data;
   logic [3:0]      w_be;
   logic            w_illegal;
   logic            w_accept;
   logic            w_push;
   logic            w_pop;
   logic [PW-1:0]   w_nxt_rd;
   logic [CW-1:0]   w_nxt_count;
   logic            w_head_is_new;

   assign In_Ready  = (r_count < DEPTH_C);
   assign Mem_Valid = (r_count != '0);
   assign Mem_Addr  = r_mem_addr;
   assign Mem_Data  = r_mem_data;
   assign Mem_Be    = r_mem_be;
   assign Misalign  = r_misalign;
   assign Count     = r_count;

   assign w_accept  = In_Valid & In_Ready;
   assign w_push    = w_accept & ~w_illegal;
   assign w_pop     = Mem_Valid & Mem_Ready;
   assign w_lane    = In_Addr[1:0];
   assign w_addr    = {In_Addr[AW-1:2], 2'b00};

   // Entry formation: replicate the narrowed field across lanes, select lanes
   // with the byte enables, and flag illegal size/alignment combinations.
   always_comb begin
      w_data    = In_Data;
      w_be      = 4'b1111;
      w_illegal = 1'b0;
      case (In_Size)
         SZ_BYTE: begin
            w_data = {4{In_Data[7:0]}};
            w_be   = 4'b0001 << w_lane;
         end
         SZ_HALF: begin
            w_data    = {2{In_Data[15:0]}};
            w_be      = 4'b0011 << w_lane;
            w_illegal = In_Addr[0];
         end
         SZ_WORD: begin
            w_illegal = |In_Addr[1:0];
         end
         default: begin
            w_be      = 4'b0000;
            w_illegal = 1'b1;
         end
      endcase
   end

   // Next read pointer and occupancy after this edge.
   always_comb begin
      w_nxt_rd    = r_rd_ptr;
      w_nxt_count = r_count;
      if (w_pop) begin
         w_nxt_rd = r_rd_ptr + 1'b1;
      end
      case ({w_push, w_pop})
         2'b10:   w_nxt_count = r_count + 1'b1;
         2'b01:   w_nxt_count = r_count - 1'b1;
         default: w_nxt_count = r_count;
      endcase
   end

   // The next head is the store being written now only when the buffer
   // otherwise drains to empty this cycle, i.e. the next read slot is the
   // slot being written.
   assign w_head_is_new = w_push && (w_nxt_rd == r_wr_ptr);

   // Write the accepted entry into the circular buffer.
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_ent_addr[r_wr_ptr] <= w_addr;
         r_ent_data[r_wr_ptr] <= w_data;
         r_ent_be[r_wr_ptr]   <= w_be;
      end
   end

   // Pointers, occupancy and the rejection pulse.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_count    <= '0;
         r_misalign <= 1'b0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + 1'b1;
         end
         r_rd_ptr   <= w_nxt_rd;
         r_count    <= w_nxt_count;
         r_misalign <= w_accept & w_illegal;
      end
   end

   // Registered head outputs: reload with the post-edge head, hold when empty.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_mem_addr <= '0;
         r_mem_data <= '0;
         r_mem_be   <= '0;
      end else if (w_nxt_count != '0) begin
         if (w_head_is_new) begin
            r_mem_addr <= w_addr;
            r_mem_data <= w_data;
            r_mem_be   <= w_be;
         end else begin
            r_mem_addr <= r_ent_addr[w_nxt_rd];
            r_mem_data <= r_ent_data[w_nxt_rd];
            r_mem_be   <= r_ent_be[w_nxt_rd];
         end
      end
   end

`ifdef STORE_NARROWER_TRUNC_CHECK_EN
   logic        r_trunc_loss;
   logic [23:0] w_up_b;
   logic [15:0] w_up_h;
   logic        w_loss_b;
   logic        w_loss_h;
   logic        w_loss;

   assign w_up_b   = In_Data[31:8];
   assign w_up_h   = In_Data[31:16];
   // Lossless when the upper bits are zero (zero extension) or copies of the
   // stored top bit (sign extension).
   assign w_loss_b = (w_up_b != '0) && (w_up_b != {24{In_Data[7]}});
   assign w_loss_h = (w_up_h != '0) && (w_up_h != {16{In_Data[15]}});
   assign w_loss   = ((In_Size == SZ_BYTE) & w_loss_b) |
                     ((In_Size == SZ_HALF) & w_loss_h);
   assign Trunc_Loss = r_trunc_loss;

   // One-cycle truncation-loss pulse for accepted legal narrow stores.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_trunc_loss <= 1'b0;
      end else begin
         r_trunc_loss <= w_push & w_loss;
      end
   end
`endif

endmodule
